// File: rtl/sap1_control_sequencer.sv
// SAP-1 hardwired control unit: six-state ring counter plus opcode decode
// into the per-state control word that steers every datapath enable/load line.
module sap1_control_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       clk_i,
   input  logic       clr_n_i,
   input  logic [3:0] opcode_i,
   output logic       cp_o,
   output logic       ep_o,
   output logic       lm_o,
   output logic       ce_o,
   output logic       li_o,
   output logic       ei_o,
   output logic       la_o,
   output logic       ea_o,
   output logic       su_o,
   output logic       eu_o,
   output logic       lb_o,
   output logic       lo_o,
   output logic       hlt_o,
   output logic [5:0] t_state_o
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tState_e;

   localparam int unsigned BIT_CP  = 12;
   localparam int unsigned BIT_EP  = 11;
   localparam int unsigned BIT_LM  = 10;
   localparam int unsigned BIT_CE  = 9;
   localparam int unsigned BIT_LI  = 8;
   localparam int unsigned BIT_EI  = 7;
   localparam int unsigned BIT_LA  = 6;
   localparam int unsigned BIT_EA  = 5;
   localparam int unsigned BIT_SU  = 4;
   localparam int unsigned BIT_EU  = 3;
   localparam int unsigned BIT_LB  = 2;
   localparam int unsigned BIT_LO  = 1;
   localparam int unsigned BIT_HLT = 0;

   tState_e     state_q, state_d;
   logic        halt_q, halt_d;
   logic        hold_q;
   logic [12:0] ctrl;

   // hold_q swallows the first rising edge after reset release so T1 spans a full cycle.
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q <= T1;
         halt_q  <= 1'b0;
         hold_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         hold_q  <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      ctrl    = '0;
      if (halt_q) begin
         ctrl[BIT_HLT] = 1'b1;
      end else begin
         case (state_q)
            T1: begin
               ctrl[BIT_EP] = 1'b1;
               ctrl[BIT_LM] = 1'b1;
            end
            T2: ctrl[BIT_CP] = 1'b1;
            T3: begin
               ctrl[BIT_CE] = 1'b1;
               ctrl[BIT_LI] = 1'b1;
            end
            T4: begin
               if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                  ctrl[BIT_EI] = 1'b1;
                  ctrl[BIT_LM] = 1'b1;
               end else if (opcode_i == OP_OUT) begin
                  ctrl[BIT_EA] = 1'b1;
                  ctrl[BIT_LO] = 1'b1;
               end else if (opcode_i == OP_HLT) begin
                  ctrl[BIT_HLT] = 1'b1;
               end
            end
            T5: begin
               if (opcode_i == OP_LDA) begin
                  ctrl[BIT_CE] = 1'b1;
                  ctrl[BIT_LA] = 1'b1;
               end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                  ctrl[BIT_CE] = 1'b1;
                  ctrl[BIT_LB] = 1'b1;
               end
            end
            T6: begin
               if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                  ctrl[BIT_EU] = 1'b1;
                  ctrl[BIT_LA] = 1'b1;
                  ctrl[BIT_SU] = (opcode_i == OP_SUB);
               end
            end
            default: ctrl = '0;
         endcase

         // A halt at T4 freezes the ring on that state and latches the sticky flag.
         if (!hold_q) begin
            case (state_q)
               T1: state_d = T2;
               T2: state_d = T3;
               T3: state_d = T4;
               T4: begin
                  if (opcode_i == OP_HLT) begin
                     state_d = T4;
                     halt_d  = 1'b1;
                  end else begin
                     state_d = T5;
                  end
               end
               T5: state_d = T6;
               T6: state_d = T1;
               default: state_d = T1;
            endcase
         end
      end
   end

   // Gating with the reset pin kills every control pulse the instant CLR_N falls.
   assign {cp_o, ep_o, lm_o, ce_o, li_o, ei_o, la_o, ea_o, su_o, eu_o, lb_o, lo_o, hlt_o} =
      ctrl & {13{clr_n_i}};
   assign t_state_o = state_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Scoreboard bench for the SAP-1 control sequencer: directed instructions,
// halt/reset corner cases and a random opcode run with bus-safety invariants.
module tb_sap1_control_sequencer;

   logic       clock = 1'b0;
   logic       clrN = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
   logic [5:0] tState;

   localparam logic [12:0] C_CP  = 13'd1 << 12;
   localparam logic [12:0] C_EP  = 13'd1 << 11;
   localparam logic [12:0] C_LM  = 13'd1 << 10;
   localparam logic [12:0] C_CE  = 13'd1 << 9;
   localparam logic [12:0] C_LI  = 13'd1 << 8;
   localparam logic [12:0] C_EI  = 13'd1 << 7;
   localparam logic [12:0] C_LA  = 13'd1 << 6;
   localparam logic [12:0] C_EA  = 13'd1 << 5;
   localparam logic [12:0] C_SU  = 13'd1 << 4;
   localparam logic [12:0] C_EU  = 13'd1 << 3;
   localparam logic [12:0] C_LB  = 13'd1 << 2;
   localparam logic [12:0] C_LO  = 13'd1 << 1;
   localparam logic [12:0] C_HLT = 13'd1;

   typedef struct {
      logic [5:0]  t;
      logic [12:0] c;
      logic        aluChk;
      logic [7:0]  aluVal;
      string       name;
   } exp_t;

   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  aReg = 8'h35;
   logic [7:0]  bReg = 8'h34;
   logic [12:0] dutCtrl;

   sap1_control_sequencer dut (
      .clk_i     (clock),
      .clr_n_i   (clrN),
      .opcode_i  (opcode),
      .cp_o      (cp),
      .ep_o      (ep),
      .lm_o      (lm),
      .ce_o      (ce),
      .li_o      (li),
      .ei_o      (ei),
      .la_o      (la),
      .ea_o      (ea),
      .su_o      (su),
      .eu_o      (eu),
      .lb_o      (lb),
      .lo_o      (lo),
      .hlt_o     (hlt),
      .t_state_o (tState)
   );

   assign dutCtrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

   // 100 MHz clock; the bench drives just after rising edges and samples on falling ones.
   always #5 clock = ~clock;

   // Hand-derived control word per T-state and opcode, straight from the decode table.
   function automatic logic [12:0] expCtrl(input logic [3:0] op, input int idx);
      logic [12:0] c;
      c = '0;
      case (idx)
         1: c = C_EP | C_LM;
         2: c = C_CP;
         3: c = C_CE | C_LI;
         4: begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) c = C_EI | C_LM;
            else if (op == 4'hE) c = C_EA | C_LO;
            else if (op == 4'hF) c = C_HLT;
         end
         5: begin
            if (op == 4'h0) c = C_CE | C_LA;
            else if (op == 4'h1 || op == 4'h2) c = C_CE | C_LB;
         end
         6: begin
            if (op == 4'h1) c = C_EU | C_LA;
            else if (op == 4'h2) c = C_SU | C_EU | C_LA;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [5:0] tOf(input int idx);
      logic [5:0] one;
      one = 6'b000001;
      return one << (idx - 1);
   endfunction

   task automatic checkOutput(input string name, input logic [5:0] tExp, input logic [12:0] cExp);
      checks++;
      if (tState !== tExp || dutCtrl !== cExp) begin
         errors++;
         $display("[TB] FAIL %s: got T=%b ctrl=%b, want T=%b ctrl=%b", name, tState, dutCtrl, tExp, cExp);
      end
   endtask

   // Each step waits for a rising edge, drives OPCODE and queues what the next sample must show.
   task automatic applyStimulus(input logic [3:0] op, input logic [5:0] t, input logic [12:0] c,
                                input string name, input logic aluChk, input logic [7:0] aluVal);
      exp_t e;
      @(posedge clock);
      #1;
      opcode = op;
      e.t = t;
      e.c = c;
      e.aluChk = aluChk;
      e.aluVal = aluVal;
      e.name = name;
      expQ.push_back(e);
   endtask

   task automatic runInstr(input logic [3:0] op, input int nStates, input string name,
                           input logic aluChk, input logic [7:0] aluVal);
      logic [3:0] junk;
      junk = (op == 4'hF) ? 4'h2 : 4'hF;
      for (int i = 1; i <= nStates; i++) begin
         applyStimulus((i < 4) ? junk : op, tOf(i), expCtrl(op, i),
                       $sformatf("%s_T%0d", name, i), aluChk && (i == 6), aluVal);
      end
   endtask

   task automatic holdReset(input string name);
      @(posedge clock);
      #1;
      clrN = 1'b0;
      applyStimulus(4'h0, 6'b000001, 13'd0, name, 1'b0, 8'h00);
   endtask

   task automatic releaseReset();
      @(posedge clock);
      #1;
      clrN = 1'b1;
      opcode = 4'h0;
      begin
         exp_t e;
         e.t = 6'b000001;
         e.c = C_EP | C_LM;
         e.aluChk = 1'b0;
         e.aluVal = 8'h00;
         e.name = "release_T1";
         expQ.push_back(e);
      end
   endtask

   // Monitor: pops one expectation per sampled cycle and also enforces the bus-safety rules.
   always @(negedge clock) begin : monitor
      exp_t       e;
      logic [7:0] bus;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput(e.name, e.t, e.c);
         if (e.aluChk) begin
            checks++;
            bus = su ? (aReg - bReg) : (aReg + bReg);
            if (!eu || bus !== e.aluVal) begin
               errors++;
               $display("[TB] FAIL %s_alu: got eu=%b bus=%h, want eu=1 bus=%h", e.name, eu, bus, e.aluVal);
            end
         end
         checks++;
         if ($countones({ep, ce, ei, ea, eu}) > 1 || (su && !eu) || (eu && !la)) begin
            errors++;
            $display("[TB] FAIL %s_invariant: got ep,ce,ei,ea,eu,su,la=%b, want one driver max and su->eu->la",
                     e.name, {ep, ce, ei, ea, eu, su, la});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200000ns, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      holdReset("reset0");
      holdReset("reset1");
      releaseReset();
      runInstr(4'h0, 6, "lda", 1'b0, 8'h00);
      runInstr(4'h2, 6, "sub", 1'b1, 8'h01);
      runInstr(4'h1, 6, "add", 1'b1, 8'h69);
      runInstr(4'hE, 6, "out", 1'b0, 8'h00);
      runInstr(4'h7, 6, "nop", 1'b0, 8'h00);

      runInstr(4'h1, 5, "addAbort", 1'b0, 8'h00);
      #5;
      clrN = 1'b0;
      #1;
      checkOutput("asyncReset", 6'b000001, 13'd0);
      #2;
      clrN = 1'b1;
      runInstr(4'h0, 6, "afterAbort", 1'b0, 8'h00);

      runInstr(4'hF, 4, "hlt", 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'(i), 6'b001000, C_HLT, $sformatf("halted%0d", i), 1'b0, 8'h00);
      end
      holdReset("haltReset");
      releaseReset();

      for (int n = 0; n < 200; n++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 14));
         runInstr(op, 6, $sformatf("rnd%0d_op%h", n, op), 1'b0, 8'h00);
      end

      @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
